// File: rtl/shifter_pkg.sv
// Shared op encoding and extend field widths for the operand-2 shifter.
package shifter_pkg;

  typedef enum logic [3:0] {
    LSL   = 4'd0,
    LSR   = 4'd1,
    ASR   = 4'd2,
    ROR   = 4'd3,
    ROR2  = 4'd4,
    RRX   = 4'd5,
    SXTB  = 4'd8,
    UXTB  = 4'd9,
    SXTH  = 4'd10,
    UXTH  = 4'd11,
    SXT24 = 4'd12,
    UXT12 = 4'd13
  } shop_e;

  localparam int unsigned FW_BYTE  = 8;
  localparam int unsigned FW_IMM12 = 12;
  localparam int unsigned FW_HALF  = 16;
  localparam int unsigned FW_BR24  = 24;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter / extender with ARM-style carry-out.
module shift_core
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 8
) (
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_cin,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_cout,
  output logic               o_err
);

  localparam int unsigned LOG = $clog2(WIDTH);
  // Wide enough to hold both the raw shift amount and WIDTH itself.
  localparam int unsigned CW  = (SHAMT_W > LOG + 1) ? SHAMT_W : LOG + 1;
  localparam logic [CW-1:0] M  = CW'(WIDTH);
  localparam logic [LOG:0]  MW = (LOG + 1)'(WIDTH);

  shop_e             w_op;
  logic [CW-1:0]     w_n;
  logic              w_zero;
  logic              w_ge_m;
  logic [CW-1:0]     w_asr_amt;
  logic [LOG-1:0]    w_r;
  logic [LOG-1:0]    w_r2;
  logic [WIDTH:0]    w_lsl;
  logic [WIDTH:0]    w_lsr;
  logic [WIDTH:0]    w_asr;
  logic [WIDTH-1:0]  w_ror;
  logic [WIDTH-1:0]  w_ror2;

  assign w_op      = shop_e'(i_op);
  assign w_n       = CW'(i_shamt);
  assign w_zero    = (w_n == '0);
  assign w_ge_m    = (w_n >= M);
  assign w_asr_amt = w_ge_m ? M : w_n;
  assign w_r       = w_n[LOG-1:0];
  assign w_r2      = {w_n[LOG-2:0], 1'b0};

  // Extra bit on each shift carries the last bit shifted out.
  assign w_lsl = {1'b0, i_data} << i_shamt;
  assign w_lsr = {i_data, 1'b0} >> i_shamt;
  assign w_asr = $signed({i_data, 1'b0}) >>> w_asr_amt;

  assign w_ror  = (i_data >> w_r)  | (i_data << (MW - {1'b0, w_r}));
  assign w_ror2 = (i_data >> w_r2) | (i_data << (MW - {1'b0, w_r2}));

  always_comb begin
    o_data = i_data;
    o_cout = i_cin;
    o_err  = 1'b0;
    unique case (w_op)
      LSL: begin
        o_data = w_lsl[WIDTH-1:0];
        o_cout = w_zero ? i_cin : w_lsl[WIDTH];
      end
      LSR: begin
        o_data = w_lsr[WIDTH:1];
        o_cout = w_zero ? i_cin : w_lsr[0];
      end
      ASR: begin
        o_data = w_asr[WIDTH:1];
        o_cout = w_zero ? i_cin : w_asr[0];
      end
      ROR: begin
        o_data = w_ror;
        o_cout = w_zero ? i_cin : w_ror[WIDTH-1];
      end
      ROR2: begin
        o_data = w_ror2;
        o_cout = w_zero ? i_cin : w_ror2[WIDTH-1];
      end
      RRX: begin
        o_data = {i_cin, i_data[WIDTH-1:1]};
        o_cout = i_data[0];
      end
      SXTB:  o_data = {{(WIDTH-FW_BYTE){i_data[FW_BYTE-1]}}, i_data[FW_BYTE-1:0]};
      UXTB:  o_data = {{(WIDTH-FW_BYTE){1'b0}}, i_data[FW_BYTE-1:0]};
      SXTH:  o_data = {{(WIDTH-FW_HALF){i_data[FW_HALF-1]}}, i_data[FW_HALF-1:0]};
      UXTH:  o_data = {{(WIDTH-FW_HALF){1'b0}}, i_data[FW_HALF-1:0]};
      SXT24: o_data = {{(WIDTH-FW_BR24){i_data[FW_BR24-1]}}, i_data[FW_BR24-1:0]};
      UXT12: o_data = {{(WIDTH-FW_IMM12){1'b0}}, i_data[FW_IMM12-1:0]};
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_extend_pipe.sv
// Two-stage valid/ready pipeline around shift_core: S1 holds the request, S2 the result.
module shift_extend_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [3:0]         in_op,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_cout,
  output logic               out_err
);

  logic               r_s1_valid;
  logic [3:0]         r_s1_op;
  logic [WIDTH-1:0]   r_s1_data;
  logic [SHAMT_W-1:0] r_s1_shamt;
  logic               r_s1_cin;

  logic               r_s2_valid;
  logic [WIDTH-1:0]   r_s2_data;
  logic               r_s2_cout;
  logic               r_s2_err;

  logic               w_s2_free;
  logic [WIDTH-1:0]   w_data;
  logic               w_cout;
  logic               w_err;

  // S2 can take a new entry when empty or being drained this cycle.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;

  shift_core #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_core (
    .i_op   (r_s1_op),
    .i_data (r_s1_data),
    .i_shamt(r_s1_shamt),
    .i_cin  (r_s1_cin),
    .o_data (w_data),
    .o_cout (w_cout),
    .o_err  (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_cin   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op    <= in_op;
        r_s1_data  <= in_data;
        r_s1_shamt <= in_shamt;
        r_s1_cin   <= in_cin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_cout  <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_free) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_data;
        r_s2_cout <= w_cout;
        r_s2_err  <= w_err;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_cout  = r_s2_cout;
  assign out_err   = r_s2_err;

endmodule

// File: tb/tb_shift_extend_pipe.sv
// Directed bench for shift_extend_pipe: op vectors, backpressure ordering, reset mid-flight.
module tb_shift_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_shamt;
  logic [3:0]  in_op;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_cout;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  shift_extend_pipe #(
    .WIDTH  (32),
    .SHAMT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cout (out_cout),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request with out_ready=1; checks acceptance, latency and result.
  task automatic run1(input string tag, input logic [3:0] op, input logic [31:0] d,
                      input logic [7:0] n, input logic c, input logic [31:0] ed,
                      input logic ec, input logic ee);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = n; in_cin = c;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // op, data, n, cin, expected data, cout, err
    run1("lsl4",    4'd0,  32'h1800_0001, 8'd4,   1'b0, 32'h8000_0010, 1'b1, 1'b0);
    run1("asr40",   4'd2,  32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run1("lsr32",   4'd1,  32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run1("ror2_4",  4'd4,  32'h0000_00FF, 8'd4,   1'b0, 32'hFF00_0000, 1'b1, 1'b0);
    run1("rrx",     4'd5,  32'h0000_0003, 8'd7,   1'b1, 32'h8000_0001, 1'b1, 1'b0);
    run1("sxtb",    4'd8,  32'h1234_5680, 8'd3,   1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
    run1("uxth",    4'd11, 32'hFFFF_8001, 8'd0,   1'b1, 32'h0000_8001, 1'b1, 1'b0);
    run1("sxt24",   4'd12, 32'h0080_0000, 8'd0,   1'b0, 32'hFF80_0000, 1'b0, 1'b0);
    run1("op14",    4'd14, 32'hDEAD_BEEF, 8'd5,   1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    run1("lsl0",    4'd0,  32'h0000_0005, 8'd0,   1'b1, 32'h0000_0005, 1'b1, 1'b0);
    run1("lsl31",   4'd0,  32'h0000_0003, 8'd31,  1'b0, 32'h8000_0000, 1'b1, 1'b0);
    run1("lsl32",   4'd0,  32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run1("lsl33",   4'd0,  32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run1("lsr1",    4'd1,  32'h0000_0003, 8'd1,   1'b0, 32'h0000_0001, 1'b1, 1'b0);
    run1("lsr255",  4'd1,  32'hFFFF_FFFF, 8'd255, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run1("asr4",    4'd2,  32'h8000_0010, 8'd4,   1'b1, 32'hF800_0001, 1'b0, 1'b0);
    run1("asr255",  4'd2,  32'h7FFF_FFFF, 8'd255, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    run1("ror8",    4'd3,  32'h1234_5678, 8'd8,   1'b1, 32'h7812_3456, 1'b0, 1'b0);
    run1("ror32",   4'd3,  32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 1'b0);
    run1("ror0",    4'd3,  32'h0000_0002, 8'd0,   1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run1("ror2_0",  4'd4,  32'h8000_0001, 8'd0,   1'b0, 32'h8000_0001, 1'b0, 1'b0);
    run1("uxt12",   4'd13, 32'hFFFF_FABC, 8'd9,   1'b0, 32'h0000_0ABC, 1'b0, 1'b0);
    run1("uxtb",    4'd9,  32'h0000_01FF, 8'd0,   1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    run1("sxth",    4'd10, 32'h0000_8000, 8'd0,   1'b1, 32'hFFFF_8000, 1'b1, 1'b0);
    run1("op6",     4'd6,  32'h0000_1234, 8'd1,   1'b0, 32'h0000_1234, 1'b0, 1'b1);

    // Backpressure: four passthrough requests (LSL #0) while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_shamt = 8'd0; in_cin = 1'b0; in_data = 32'hA;
    @(negedge clk);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'hB;
    @(negedge clk);
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'hC;
    @(negedge clk);
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_vld", 32'(out_valid), 32'd1);
    chk("bp_hold_data", out_data, 32'hA);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    chk("bp_out_a", out_data, 32'hA);
    @(posedge clk); #1;
    in_data = 32'hD;
    @(negedge clk);
    chk("bp_out_b_vld", 32'(out_valid), 32'd1);
    chk("bp_out_b", out_data, 32'hB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_c_vld", 32'(out_valid), 32'd1);
    chk("bp_out_c", out_data, 32'hC);
    @(posedge clk);
    @(negedge clk);
    chk("bp_out_d_vld", 32'(out_valid), 32'd1);
    chk("bp_out_d", out_data, 32'hD);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_shamt = 8'd0; in_data = 32'h1111_1111;
    @(posedge clk); #1;
    in_data = 32'h2222_2222;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rm_full_vld", 32'(out_valid), 32'd1);
    chk("rm_full_rdy", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_vld", 32'(out_valid), 32'd0);
    chk("rm_data", out_data, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    run1("after_rst", 4'd1, 32'h0000_0100, 8'd4, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("after_rst_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
